// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared CRC-32 constants, scheduler state and job record
package crc_pkg;

  localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

  // Wide enough for the largest supported requester count (8).
  localparam int JOB_ID_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [255:0]          data;
    logic [31:0]           exp_crc;
    logic                  check;
    logic [JOB_ID_W-1:0]   id;
  } job_t;

  // One reflected CRC-32 byte step, byte consumed LSB-first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_job_sched_if.sv
// rtl/crc_job_sched_if.sv - requester and response handshake bundle
interface crc_job_sched_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*256-1:0] req_data;
  logic [NUM_REQ*32-1:0]  req_exp_crc;
  logic [NUM_REQ-1:0]     req_check;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [31:0]            rsp_crc;
  logic                   rsp_match;

  // Requesters plus response consumer.
  modport master (
    output req_valid, req_data, req_exp_crc, req_check, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_crc, rsp_match
  );

  // The scheduler.
  modport slave (
    input  req_valid, req_data, req_exp_crc, req_check, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_crc, rsp_match
  );
endinterface

// File: rtl/crc32_byte_engine.sv
// rtl/crc32_byte_engine.sv - byte-serial CRC-32 over a 32-byte block
module crc32_byte_engine
  import crc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] data,
  output logic [31:0]  crc,
  output logic         done
);
  // data must stay stable while running; the scheduler feeds its latched job.
  logic        running_q;
  logic [4:0]  idx_q;
  logic [31:0] acc_q;
  logic [31:0] crc_q;
  logic        done_q;
  logic [7:0]  cur_byte;
  logic [31:0] acc_next;

  // Byte idx is taken from the top of the block downwards: ~idx == 31 - idx.
  assign cur_byte = data[{~idx_q, 3'b000} +: 8];
  assign acc_next = crc32_byte(acc_q, cur_byte);
  assign crc      = crc_q;
  assign done     = done_q;

  // One byte per cycle after start; final XOR applied on the last byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running_q <= 1'b0;
      idx_q     <= '0;
      acc_q     <= '0;
      crc_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!running_q) begin
        if (start) begin
          running_q <= 1'b1;
          idx_q     <= '0;
          acc_q     <= CRC32_INIT;
        end
      end else begin
        acc_q <= acc_next;
        idx_q <= idx_q + 5'd1;
        if (idx_q == 5'd31) begin
          running_q <= 1'b0;
          done_q    <= 1'b1;
          crc_q     <= acc_next ^ CRC32_XOROUT;
        end
      end
    end
  end
endmodule

// File: rtl/crc_job_sched.sv
// rtl/crc_job_sched.sv - round-robin arbiter sequencing jobs through one CRC engine
module crc_job_sched
  import crc_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic           clk,
  input  logic           rst,
  crc_job_sched_if.slave bus,
  output logic           busy,
  output logic [15:0]    job_cnt
);
  localparam int ID_W = $clog2(NUM_REQ);

  sched_state_t    state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  job_t            job_q, job_d;
  logic            rsp_valid_q;
  logic [31:0]     rsp_crc_q;
  logic            rsp_match_q;
  logic [15:0]     job_cnt_q;
  logic [ID_W-1:0] win;
  logic            grant;
  logic            accept;
  logic            eng_done;
  logic [31:0]     eng_crc;

  // First valid at or after ptr; otherwise the lowest valid (wrap-around).
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                               input logic [ID_W-1:0] ptr);
    logic [ID_W-1:0] hi, lo;
    logic            hi_ok;
    hi    = '0;
    lo    = '0;
    hi_ok = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (|(v & (NUM_REQ'(1) << k))) begin
        lo = ID_W'(k);
        if (ID_W'(k) >= ptr) begin
          hi    = ID_W'(k);
          hi_ok = 1'b1;
        end
      end
    end
    return hi_ok ? hi : lo;
  endfunction

  assign win           = rr_pick(bus.req_valid, rr_ptr_q);
  assign grant         = (state_q == IDLE) && (|bus.req_valid);
  assign accept        = rsp_valid_q && bus.rsp_ready;
  assign bus.req_ready = grant ? (NUM_REQ'(1) << win) : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = ID_W'(job_q.id);
  assign bus.rsp_crc   = rsp_crc_q;
  assign bus.rsp_match = rsp_match_q;
  assign busy          = (state_q != IDLE);
  assign job_cnt       = job_cnt_q;

  crc32_byte_engine u_engine (
    .clk   (clk),
    .rst   (rst),
    .start (grant),
    .data  (job_q.data),
    .crc   (eng_crc),
    .done  (eng_done)
  );

  // Next state, pointer advance and winner payload capture.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    job_d    = job_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          job_d.data    = 256'(bus.req_data >> {win, 8'b0});
          job_d.exp_crc = 32'(bus.req_exp_crc >> {win, 5'b0});
          job_d.check   = |(bus.req_check & (NUM_REQ'(1) << win));
          job_d.id      = JOB_ID_W'(win);
          rr_ptr_d      = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
          state_d       = RUN;
        end
      end
      RUN:     if (eng_done) state_d = RESP;
      RESP:    if (accept)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Scheduler state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      job_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      job_q    <= job_d;
    end
  end

  // Response capture on engine completion, release and count on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_crc_q   <= '0;
      rsp_match_q <= 1'b0;
      job_cnt_q   <= '0;
    end else if (state_q == RUN && eng_done) begin
      rsp_valid_q <= 1'b1;
      rsp_crc_q   <= eng_crc;
      rsp_match_q <= !job_q.check || (eng_crc == job_q.exp_crc);
    end else if (accept) begin
      rsp_valid_q <= 1'b0;
      job_cnt_q   <= job_cnt_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_crc_job_sched.sv
// tb/tb_crc_job_sched.sv - scoreboard bench for crc_job_sched
module tb_crc_job_sched;
  localparam int N = 4;
  localparam logic [31:0] ZERO_CRC = 32'h190A55AD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [15:0] job_cnt;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  logic [255:0] dat [N];
  logic [31:0]  exp_c [N];
  logic [N-1:0] chk;

  typedef struct {
    int          id;
    logic [31:0] crc;
    logic        match;
  } exp_t;
  exp_t sb[$];

  crc_job_sched_if #(.NUM_REQ(N)) bus();

  crc_job_sched #(.NUM_REQ(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .job_cnt (job_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    bus.req_data    = '0;
    bus.req_exp_crc = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_data[256*i +: 256] = dat[i];
      bus.req_exp_crc[32*i +: 32] = exp_c[i];
    end
    bus.req_check = chk;
  end

  function automatic logic [31:0] model_crc(input logic [255:0] d);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int by = 31; by >= 0; by--) begin
      for (int bt = 0; bt < 8; bt++) begin
        fb = c[0] ^ d[8*by + bt];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c ^ 32'hFFFFFFFF;
  endfunction

  task automatic rand_job(input int i, input bit want_match);
    dat[i] = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
    chk[i] = want_match ? 1'b1 : 1'($urandom_range(0, 1));
    exp_c[i] = (want_match || $urandom_range(0, 1) == 1) ? model_crc(dat[i]) : $urandom();
  endtask

  task automatic push_exp(input int i);
    exp_t e;
    e.id    = i;
    e.crc   = model_crc(dat[i]);
    e.match = !chk[i] || (e.crc == exp_c[i]);
    sb.push_back(e);
  endtask

  task automatic pop_exp(output exp_t e);
    if (sb.size() == 0) begin
      e.id = -1; e.crc = '0; e.match = 1'bx;
    end else begin
      e = sb.pop_front();
    end
  endtask

  task automatic wait_grant(output int t, output bit to);
    to = 1'b1; t = 0;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (bus.req_ready != '0) begin t = cyc; to = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_rsp(output int t, output bit to);
    to = 1'b1; t = 0;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (bus.rsp_valid === 1'b1) begin t = cyc; to = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    bus.req_valid = '0; bus.rsp_ready = 1'b0; chk = '0;
    for (int i = 0; i < N; i++) begin dat[i] = '0; exp_c[i] = '0; end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", bus.rsp_id); end
    checks++; if (bus.rsp_crc !== 32'h0) begin errors++; $display("FAIL reset_rsp_crc: got %h want 0", bus.rsp_crc); end
    checks++; if (bus.rsp_match !== 1'b0) begin errors++; $display("FAIL reset_rsp_match: got %b want 0", bus.rsp_match); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (job_cnt !== 16'h0) begin errors++; $display("FAIL reset_job_cnt: got %h want 0", job_cnt); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single;
    int t0, t1; bit to; exp_t e;
    @(negedge clk);
    dat[0] = '0; chk[0] = 1'b0; exp_c[0] = '0;
    bus.rsp_ready = 1'b1; bus.req_valid = 4'b0001;
    wait_grant(t0, to);
    checks++; if (to || bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b timeout=%0d want 0001", bus.req_ready, to); end
    push_exp(0);
    @(negedge clk); bus.req_valid = '0;
    wait_rsp(t1, to);
    checks++; if (to || t1 - t0 != 34) begin errors++; $display("FAIL single_latency: got %0d timeout=%0d want 34", t1 - t0, to); end
    pop_exp(e);
    checks++; if (int'(bus.rsp_id) !== e.id || bus.rsp_crc !== e.crc || bus.rsp_match !== e.match) begin errors++; $display("FAIL single_rsp: got id=%0d crc=%h m=%b want id=%0d crc=%h m=%b", bus.rsp_id, bus.rsp_crc, bus.rsp_match, e.id, e.crc, e.match); end
    checks++; if (bus.rsp_crc !== ZERO_CRC) begin errors++; $display("FAIL single_known_crc: got %h want %h", bus.rsp_crc, ZERO_CRC); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    @(negedge clk); #1;
    checks++; if (job_cnt !== 16'd1 || bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done: got cnt=%0d v=%b busy=%b want cnt=1 v=0 busy=0", job_cnt, bus.rsp_valid, busy); end
  endtask

  task automatic test_compare;
    logic [31:0] exps [2];
    logic        want [2];
    int t; bit to; exp_t e;
    exps[0] = 32'h190A55AD; want[0] = 1'b1;
    exps[1] = 32'h190A55AC; want[1] = 1'b0;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      dat[2] = '0; chk[2] = 1'b1; exp_c[2] = exps[r];
      bus.req_valid = 4'b0100;
      wait_grant(t, to);
      checks++; if (to || bus.req_ready !== 4'b0100) begin errors++; $display("FAIL compare_grant%0d: got %b timeout=%0d want 0100", r, bus.req_ready, to); end
      push_exp(2);
      @(negedge clk); bus.req_valid = '0;
      wait_rsp(t, to);
      pop_exp(e);
      checks++; if (to || int'(bus.rsp_id) !== e.id || bus.rsp_crc !== e.crc || bus.rsp_match !== e.match) begin errors++; $display("FAIL compare_rsp%0d: got id=%0d crc=%h m=%b want id=%0d crc=%h m=%b", r, bus.rsp_id, bus.rsp_crc, bus.rsp_match, e.id, e.crc, e.match); end
      checks++; if (bus.rsp_match !== want[r] || bus.rsp_crc !== ZERO_CRC) begin errors++; $display("FAIL compare_match%0d: got m=%b crc=%h want m=%b crc=%h", r, bus.rsp_match, bus.rsp_crc, want[r], ZERO_CRC); end
      @(negedge clk);
    end
  endtask

  task automatic test_fairness;
    int t, tprev, tr; bit to; exp_t e;
    logic [N-1:0] want_rdy;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < N; i++) rand_job(i, 1'b0);
    bus.rsp_ready = 1'b1; bus.req_valid = 4'b1111;
    tprev = 0;
    for (int k = 0; k < 8; k++) begin
      wait_grant(t, to);
      want_rdy = 4'b0001 << (k % N);
      checks++; if (to || bus.req_ready !== want_rdy) begin errors++; $display("FAIL fair_grant%0d: got %b timeout=%0d want %b", k, bus.req_ready, to, want_rdy); end
      if (to) break;
      if (k > 0) begin
        checks++; if (t - tprev != 35) begin errors++; $display("FAIL fair_spacing%0d: got %0d want 35", k, t - tprev); end
      end
      push_exp(k % N);
      tprev = t;
      @(negedge clk);
      rand_job(k % N, 1'b0);
      wait_rsp(tr, to);
      pop_exp(e);
      checks++; if (to || int'(bus.rsp_id) !== e.id || bus.rsp_crc !== e.crc || bus.rsp_match !== e.match) begin errors++; $display("FAIL fair_rsp%0d: got id=%0d crc=%h m=%b want id=%0d crc=%h m=%b", k, bus.rsp_id, bus.rsp_crc, bus.rsp_match, e.id, e.crc, e.match); end
    end
    bus.req_valid = '0;
    @(negedge clk); #1;
    checks++; if (job_cnt !== 16'd8) begin errors++; $display("FAIL fair_count: got %0d want 8", job_cnt); end
  endtask

  task automatic test_back_pressure;
    int t, ta; bit to; exp_t e;
    logic [1:0] cid; logic [31:0] ccrc; logic cm;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    rand_job(1, 1'b0); rand_job(3, 1'b0);
    bus.req_valid = 4'b0010;
    wait_grant(t, to);
    checks++; if (to || bus.req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b timeout=%0d want 0010", bus.req_ready, to); end
    push_exp(1);
    @(negedge clk); bus.req_valid = 4'b1000;
    wait_rsp(t, to);
    pop_exp(e);
    checks++; if (to || int'(bus.rsp_id) !== e.id || bus.rsp_crc !== e.crc || bus.rsp_match !== e.match) begin errors++; $display("FAIL bp_rsp: got id=%0d crc=%h m=%b want id=%0d crc=%h m=%b", bus.rsp_id, bus.rsp_crc, bus.rsp_match, e.id, e.crc, e.match); end
    cid = 2'(e.id); ccrc = e.crc; cm = e.match;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk); #1;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== cid || bus.rsp_crc !== ccrc || bus.rsp_match !== cm || busy !== 1'b1 || bus.req_ready !== 4'b0) begin errors++; $display("FAIL bp_hold%0d: got v=%b id=%0d crc=%h m=%b busy=%b rdy=%b want v=1 id=%0d crc=%h m=%b busy=1 rdy=0000", n, bus.rsp_valid, bus.rsp_id, bus.rsp_crc, bus.rsp_match, busy, bus.req_ready, cid, ccrc, cm); end
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1; ta = cyc;
    @(negedge clk);
    wait_grant(t, to);
    checks++; if (to || t != ta + 1 || bus.req_ready !== 4'b1000) begin errors++; $display("FAIL bp_next_grant: got %b at +%0d timeout=%0d want 1000 at +1", bus.req_ready, t - ta, to); end
    push_exp(3);
    @(negedge clk); bus.req_valid = '0;
    wait_rsp(t, to);
    pop_exp(e);
    checks++; if (to || int'(bus.rsp_id) !== e.id || bus.rsp_crc !== e.crc || bus.rsp_match !== e.match) begin errors++; $display("FAIL bp_rsp2: got id=%0d crc=%h m=%b want id=%0d crc=%h m=%b", bus.rsp_id, bus.rsp_crc, bus.rsp_match, e.id, e.crc, e.match); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_job;
    int t; bit to; bit bad; exp_t e;
    @(negedge clk);
    rand_job(0, 1'b0);
    bus.rsp_ready = 1'b1; bus.req_valid = 4'b0001;
    wait_grant(t, to);
    checks++; if (to || bus.req_ready !== 4'b0001) begin errors++; $display("FAIL abort_grant: got %b timeout=%0d want 0001", bus.req_ready, to); end
    @(negedge clk); bus.req_valid = '0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd0 || bus.rsp_crc !== 32'h0 || bus.rsp_match !== 1'b0 || busy !== 1'b0 || job_cnt !== 16'h0) begin errors++; $display("FAIL abort_outputs: got rdy=%b v=%b id=%0d crc=%h m=%b busy=%b cnt=%0d want all 0", bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_crc, bus.rsp_match, busy, job_cnt); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk); #1;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL abort_quiet: got activity=%b want 0", bad); end
    @(negedge clk);
    rand_job(1, 1'b1);
    bus.req_valid = 4'b0010;
    wait_grant(t, to);
    checks++; if (to || bus.req_ready !== 4'b0010) begin errors++; $display("FAIL abort_regrant: got %b timeout=%0d want 0010", bus.req_ready, to); end
    push_exp(1);
    @(negedge clk); bus.req_valid = '0;
    wait_rsp(t, to);
    pop_exp(e);
    checks++; if (to || int'(bus.rsp_id) !== e.id || bus.rsp_crc !== e.crc || bus.rsp_match !== 1'b1) begin errors++; $display("FAIL abort_next_rsp: got id=%0d crc=%h m=%b want id=%0d crc=%h m=1", bus.rsp_id, bus.rsp_crc, bus.rsp_match, e.id, e.crc); end
    @(negedge clk); #1;
    checks++; if (job_cnt !== 16'd1) begin errors++; $display("FAIL abort_count: got %0d want 1", job_cnt); end
  endtask

  task automatic test_cnt_wrap;
    int t; bit to; exp_t e;
    @(negedge clk);
    force dut.job_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.job_cnt_q;
    #1;
    checks++; if (job_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h want ffff", job_cnt); end
    @(negedge clk);
    rand_job(2, 1'b0);
    bus.req_valid = 4'b0100;
    wait_grant(t, to);
    push_exp(2);
    @(negedge clk); bus.req_valid = '0;
    wait_rsp(t, to);
    pop_exp(e);
    checks++; if (to || int'(bus.rsp_id) !== e.id || bus.rsp_crc !== e.crc || bus.rsp_match !== e.match) begin errors++; $display("FAIL wrap_rsp: got id=%0d crc=%h m=%b want id=%0d crc=%h m=%b", bus.rsp_id, bus.rsp_crc, bus.rsp_match, e.id, e.crc, e.match); end
    @(negedge clk); #1;
    checks++; if (job_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_count: got %h want 0000", job_cnt); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_compare();
    test_fairness();
    test_back_pressure();
    test_reset_mid_job();
    test_cnt_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
